// File: rtl/count_match_monitor.sv
// Watches a free-running/loadable up counter, classifies each change as step,
// wrap or jump, and counts compare matches while armed until a target is hit.
module count_match_monitor #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic [EVT_W-1:0] target,
  input  logic             start,
  input  logic             clear,
  output logic             match_pulse,
  output logic             wrap_pulse,
  output logic             jump_pulse,
  output logic [EVT_W-1:0] match_cnt,
  output logic [EVT_W-1:0] wrap_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] COUNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] COUNT_ONES = {WIDTH{1'b1}};
  localparam logic [EVT_W-1:0] EVT_ZERO   = {EVT_W{1'b0}};
  localparam logic [EVT_W-1:0] EVT_ONE    = EVT_W'(1);
  localparam logic [EVT_W-1:0] EVT_MAX    = {EVT_W{1'b1}};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] prev_q;
  logic             prev_valid;
  logic             changed;
  logic             step;
  logic             wrap;
  logic             jump;
  logic             match;
  logic [EVT_W-1:0] target_q;
  logic [EVT_W-1:0] target_next;
  logic [EVT_W-1:0] match_cnt_next;
  logic [EVT_W-1:0] wrap_cnt_next;

  // The +1 compare is done at WIDTH bits so all-ones -> zero counts as a step.
  always_comb begin
    changed = prev_valid && (count_in != prev_q);
    step    = changed && (count_in == prev_q + COUNT_ONE);
    wrap    = step && (prev_q == COUNT_ONES);
    jump    = changed && !step;
    match   = changed && (count_in == cmp_val);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q      <= {WIDTH{1'b0}};
      prev_valid  <= 1'b0;
      match_pulse <= 1'b0;
      wrap_pulse  <= 1'b0;
      jump_pulse  <= 1'b0;
    end else begin
      prev_q      <= count_in;
      prev_valid  <= 1'b1;
      match_pulse <= match;
      wrap_pulse  <= wrap;
      jump_pulse  <= jump;
    end
  end

  // busy/done are registered alongside state from the same next-state value.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ARMED);
      done  <= (state_next == DONE);
    end
  end

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next = (target == EVT_ZERO) ? DONE : ARMED;
          end else begin
            state_next = IDLE;
          end
        end
        ARMED: begin
          if (match && ((match_cnt + EVT_ONE) == target_q)) begin
            state_next = DONE;
          end else begin
            state_next = ARMED;
          end
        end
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    target_next    = target_q;
    match_cnt_next = match_cnt;
    wrap_cnt_next  = wrap_cnt;
    if (clear) begin
      match_cnt_next = EVT_ZERO;
      wrap_cnt_next  = EVT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            target_next    = target;
            match_cnt_next = EVT_ZERO;
            wrap_cnt_next  = EVT_ZERO;
          end else begin
            target_next = target_q;
          end
        end
        ARMED: begin
          if (match) begin
            match_cnt_next = match_cnt + EVT_ONE;
          end else begin
            match_cnt_next = match_cnt;
          end
          if (wrap && (wrap_cnt != EVT_MAX)) begin
            wrap_cnt_next = wrap_cnt + EVT_ONE;
          end else begin
            wrap_cnt_next = wrap_cnt;
          end
        end
        DONE: begin
          match_cnt_next = match_cnt;
          wrap_cnt_next  = wrap_cnt;
        end
        default: begin
          match_cnt_next = EVT_ZERO;
          wrap_cnt_next  = EVT_ZERO;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      target_q  <= EVT_ZERO;
      match_cnt <= EVT_ZERO;
      wrap_cnt  <= EVT_ZERO;
    end else begin
      target_q  <= target_next;
      match_cnt <= match_cnt_next;
      wrap_cnt  <= wrap_cnt_next;
    end
  end

endmodule

// File: tb/tb_count_match_monitor.sv
// Directed-vector bench: each row pushes its hand-derived post-edge outputs,
// a monitor pops one entry per clock and compares.
module tb_count_match_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] count_in = 4'd0;
  logic [3:0] cmp_val = 4'd5;
  logic [1:0] target = 2'd0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic       match_pulse, wrap_pulse, jump_pulse, busy, done;
  logic [1:0] match_cnt, wrap_cnt;

  logic [3:0] cmp_v = 4'd5;
  logic [1:0] tgt_v = 2'd0;
  logic [8:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  count_match_monitor #(.WIDTH(4), .EVT_W(2)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .cmp_val(cmp_val),
    .target(target), .start(start), .clear(clear),
    .match_pulse(match_pulse), .wrap_pulse(wrap_pulse), .jump_pulse(jump_pulse),
    .match_cnt(match_cnt), .wrap_cnt(wrap_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // e = {match, wrap, jump, match_cnt[1:0], wrap_cnt[1:0], busy, done} after the edge
  task automatic vec(input logic r, input logic [3:0] c, input logic s, input logic cl,
                     input logic [8:0] e);
    @(negedge clk);
    reset    = r;
    count_in = c;
    start    = s;
    clear    = cl;
    cmp_val  = cmp_v;
    target   = tgt_v;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("match_pulse", int'(match_pulse), int'(e[8]));
      chk("wrap_pulse",  int'(wrap_pulse),  int'(e[7]));
      chk("jump_pulse",  int'(jump_pulse),  int'(e[6]));
      chk("match_cnt",   int'(match_cnt),   int'(e[5:4]));
      chk("wrap_cnt",    int'(wrap_cnt),    int'(e[3:2]));
      chk("busy",        int'(busy),        int'(e[1]));
      chk("done",        int'(done),        int'(e[0]));
    end
  end

  initial begin
    // reset, then free run 0..15 -> 0 -> 1
    vec(1'b1, 4'd0, 1'b0, 1'b0, 9'b000_00_00_00);
    vec(1'b1, 4'd0, 1'b0, 1'b0, 9'b000_00_00_00);
    for (int i = 0; i < 16; i++) begin
      vec(1'b0, 4'(i), 1'b0, 1'b0, {(i == 5), 8'b0000_0000});
    end
    vec(1'b0, 4'd0, 1'b0, 1'b0, 9'b010_00_00_00);
    vec(1'b0, 4'd1, 1'b0, 1'b0, 9'b000_00_00_00);

    // arm with target 3, cmp 5
    tgt_v = 2'd3;
    vec(1'b0, 4'd2,  1'b1, 1'b0, 9'b000_00_00_10);
    vec(1'b0, 4'd3,  1'b0, 1'b0, 9'b000_00_00_10);
    vec(1'b0, 4'd4,  1'b0, 1'b0, 9'b000_00_00_10);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b100_01_00_10);
    vec(1'b0, 4'd6,  1'b0, 1'b0, 9'b000_01_00_10);
    vec(1'b0, 4'd4,  1'b0, 1'b0, 9'b001_01_00_10);
    vec(1'b0, 4'd13, 1'b0, 1'b0, 9'b001_01_00_10);
    vec(1'b0, 4'd13, 1'b0, 1'b0, 9'b000_01_00_10);
    vec(1'b0, 4'd14, 1'b0, 1'b0, 9'b000_01_00_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b000_01_00_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_01_01_10);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b101_10_01_10);
    // hold at 5: start ignored while armed, cmp_val change alone is no match
    tgt_v = 2'd0;
    vec(1'b0, 4'd5,  1'b1, 1'b0, 9'b000_10_01_10);
    tgt_v = 2'd3;
    cmp_v = 4'd3;
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b000_10_01_10);
    cmp_v = 4'd5;
    for (int i = 0; i < 7; i++) begin
      vec(1'b0, 4'd5, 1'b0, 1'b0, 9'b000_10_01_10);
    end
    vec(1'b0, 4'd6,  1'b0, 1'b0, 9'b000_10_01_10);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b101_11_01_01);
    // DONE: pulses continue, counters frozen, start ignored
    vec(1'b0, 4'd6,  1'b0, 1'b0, 9'b000_11_01_01);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b101_11_01_01);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_11_01_01);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_11_01_01);
    vec(1'b0, 4'd0,  1'b1, 1'b0, 9'b000_11_01_01);
    vec(1'b0, 4'd0,  1'b0, 1'b1, 9'b000_00_00_00);

    // target 0 goes straight to DONE
    tgt_v = 2'd0;
    vec(1'b0, 4'd0,  1'b1, 1'b0, 9'b000_00_00_01);
    vec(1'b0, 4'd0,  1'b0, 1'b1, 9'b000_00_00_00);
    // start+clear together in ARMED -> IDLE with counters zeroed
    tgt_v = 2'd2;
    vec(1'b0, 4'd0,  1'b1, 1'b0, 9'b000_00_00_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_00_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_01_10);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b101_01_01_10);
    vec(1'b0, 4'd5,  1'b1, 1'b1, 9'b000_00_00_00);

    // five wraps saturate the 2-bit wrap counter
    tgt_v = 2'd3;
    vec(1'b0, 4'd5,  1'b1, 1'b0, 9'b000_00_00_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_00_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_01_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_01_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_10_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_10_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_11_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_11_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_11_10);
    vec(1'b0, 4'd15, 1'b0, 1'b0, 9'b001_00_11_10);
    vec(1'b0, 4'd0,  1'b0, 1'b0, 9'b010_00_11_10);

    // reset while armed; first sample afterwards produces no event
    vec(1'b1, 4'd3,  1'b0, 1'b0, 9'b000_00_00_00);
    vec(1'b0, 4'd3,  1'b0, 1'b0, 9'b000_00_00_00);
    vec(1'b0, 4'd4,  1'b0, 1'b0, 9'b000_00_00_00);
    vec(1'b0, 4'd5,  1'b0, 1'b0, 9'b100_00_00_00);

    @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_match_monitor.md
Name: count_match_monitor

Overview:
Downstream consumer of the loadable 4-bit binary up counter's count output. Samples the count every clock and classifies each change as a step, a wrap (max->0) or a jump (load/discontinuity), emitting one-cycle event pulses for each. An arm/done FSM counts compare matches against a programmable value and raises done after a programmed number of matches, giving software a "count N passes of value X" timer on top of the counter.

Parameters:
WIDTH, 4, width of the monitored count and of the compare value
EVT_W, 8, width of the match target, match counter and wrap counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
count_in  input  WIDTH  count from the up counter
cmp_val  input  WIDTH  compare value, sampled continuously
target  input  EVT_W  number of matches to done, latched on accepted start
start  input  1  arm request, one-cycle pulse
clear  input  1  return to IDLE and zero counters
match_pulse  output  1  count changed to cmp_val
wrap_pulse  output  1  count stepped from all-ones to zero
jump_pulse  output  1  count changed but not by +1 (load)
match_cnt  output  EVT_W  matches counted while ARMED
wrap_cnt  output  EVT_W  wraps counted while ARMED, saturating
busy  output  1  FSM in ARMED
done  output  1  FSM in DONE

Behaviour:
- Reset (synchronous, active-high): prev_q=0, prev_valid=0, state=IDLE, all pulses 0, match_cnt=0, wrap_cnt=0, target_q=0, busy=0, done=0.
- prev_q <= count_in every cycle; prev_valid <= 1 the first cycle after reset deasserts.
- changed = prev_valid & (count_in != prev_q); step = changed & (count_in == prev_q+1 mod 2^WIDTH); wrap = step & (prev_q == all ones); jump = changed & ~step; match = changed & (count_in == cmp_val).
- Held/stalled count produces no events; first sample after reset produces no events.
- Pulses registered: asserted exactly one cycle after the clk edge where count_in carrying the event was sampled; active in all FSM states; match and jump/wrap may assert together.
- FSM states IDLE, ARMED, DONE. clear has priority over start in every state.
- IDLE: start -> ARMED, latch target_q=target, zero match_cnt and wrap_cnt. If target==0, start -> DONE directly with counters zeroed.
- ARMED: match increments match_cnt; if match_cnt+1 == target_q on that match, go DONE in same edge. wrap increments wrap_cnt, saturates at 2^EVT_W-1. start ignored.
- DONE: counters hold for readback; start ignored; matches/wraps not counted; pulses still generated.
- clear (any state): -> IDLE, match_cnt=0, wrap_cnt=0; pulses unaffected.
- busy = (state==ARMED), done = (state==DONE), both registered with state.
- Reset mid-ARMED: immediate return to reset values on next edge, including prev_valid=0.
- cmp_val change does not itself generate a match; only a count change onto cmp_val does.

Test Plan:
- Reset 2 cycles, counter free-runs 0..15..0 -> no pulses on first sample, wrap_pulse once per 16 cycles one cycle after count_in=0 sampled, jump_pulse never.
- cmp_val=5, target=3, start, free run -> match_pulse each time count reaches 5; done=1, busy=0, match_cnt=3 on the edge of the 3rd match; later matches leave match_cnt at 3.
- Counter loaded to 13 from 4 while ARMED -> jump_pulse one cycle later, no wrap_pulse; load to 13 while count already 13 -> no pulse.
- Counter held at 5 (cmp_val=5) for 10 cycles -> single match_pulse only.
- target=0, start -> done=1 next edge, match_cnt=0; start and clear same cycle in ARMED -> IDLE, counters 0.
- EVT_W=2, 5 wraps while ARMED -> wrap_cnt saturates at 3; reset asserted mid-ARMED -> state IDLE, all outputs 0 next edge.
